// File: rtl/sll_64b_pkg.sv
// sll_64b_pkg: shared types, widths and helper for the iterative 64-bit
// left shifter (sll_64b_iter) and its per-cycle step stage (sll_64b_step).
//   sll_state_t : FSM encoding (IDLE, SHIFT)
//   DATA_W      : operand/result width
//   SHAMT_W     : shift-amount port width
//   CNT_W       : remaining-count width, one bit wider than SHAMT_W so the
//                 min() against STEP (up to 32) never overflows
//   step_amt    : min(cnt, step)
package sll_64b_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sll_state_t;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;
  localparam int CNT_W   = 7;

  function automatic logic [CNT_W-1:0] step_amt(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] step);
    return (cnt < step) ? cnt : step;
  endfunction

endpackage

// File: rtl/sll_64b_step.sv
// sll_64b_step: combinational left shift (zero fill) of a 64-bit word by
// i_amt bits. When SLL_64B_ITER_ROTATE_EN is defined an extra i_rot input
// selects a left rotate instead; i_amt=0 leaves the word unchanged either way.
// Ports:
//   i_data [63:0] : word to shift
//   i_amt  [6:0]  : shift amount, 0..STEP (never above 32)
//   i_rot         : (SLL_64B_ITER_ROTATE_EN only) 1 = rotate, 0 = shift
//   o_data [63:0] : shifted/rotated word
module sll_64b_step
  import sll_64b_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_amt,
`ifdef SLL_64B_ITER_ROTATE_EN
  input  logic              i_rot,
`endif
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shl;

  assign w_shl = i_data << i_amt;

`ifdef SLL_64B_ITER_ROTATE_EN
  logic [DATA_W-1:0] w_wrap;
  logic [CNT_W-1:0]  w_back;

  // For i_amt=0 the back-shift is 64, which yields all zeros, so the
  // rotate degenerates to the identity without a special case.
  assign w_back = CNT_W'(DATA_W) - i_amt;
  assign w_wrap = i_data >> w_back;
  assign o_data = i_rot ? (w_shl | w_wrap) : w_shl;
`else
  assign o_data = w_shl;
`endif

endmodule

// File: rtl/sll_64b_iter.sv
// sll_64b_iter: iterative 64-bit logical left shifter. Shifts at most
// STEP = 2**STEP_LOG2 bits per clock. init_i starts an operation (only in
// IDLE); done_o pulses for one cycle when data_o takes the new result.
// Optional feature macro: SLL_64B_ITER_ROTATE_EN adds rot_i (rotate left).
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   init_i       : start request, sampled in IDLE only
//   shift_i[5:0] : shift amount, sampled with init_i
//   data_i[63:0] : operand, sampled with init_i
//   rot_i        : (SLL_64B_ITER_ROTATE_EN only) rotate instead of shift
//   busy_o       : high while in SHIFT
//   done_o       : one-cycle pulse, data_o valid from this cycle on
//   data_o[63:0] : result, held until the next done_o
//   dbg_state_o  : current FSM state
// Handshake: an init_i seen in IDLE is accepted on that edge; init_i is
// ignored while busy_o is high (no queuing); exactly one done_o follows
// each accepted init unless rst_i aborts the operation.
module sll_64b_iter
  import sll_64b_pkg::*;
#(
  parameter int STEP_LOG2 = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_i,
  input  logic [SHAMT_W-1:0] shift_i,
  input  logic [DATA_W-1:0]  data_i,
`ifdef SLL_64B_ITER_ROTATE_EN
  input  logic               rot_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  data_o,
  output sll_state_t         dbg_state_o
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(1) << STEP_LOG2;

  sll_state_t        r_state, w_state_n;
  logic [DATA_W-1:0] r_work,  w_work_n;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_n;
  logic [DATA_W-1:0] r_data,  w_data_n;
  logic              r_done,  w_done_n;

  logic [CNT_W-1:0]  w_amt;
  logic [DATA_W-1:0] w_step;

`ifdef SLL_64B_ITER_ROTATE_EN
  logic r_rot, w_rot_n;
`endif

  assign w_amt = step_amt(r_cnt, STEP);

  sll_64b_step u_step (
    .i_data (r_work),
    .i_amt  (w_amt),
`ifdef SLL_64B_ITER_ROTATE_EN
    .i_rot  (r_rot),
`endif
    .o_data (w_step)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
`ifdef SLL_64B_ITER_ROTATE_EN
      r_rot   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_work  <= w_work_n;
      r_cnt   <= w_cnt_n;
      r_data  <= w_data_n;
      r_done  <= w_done_n;
`ifdef SLL_64B_ITER_ROTATE_EN
      r_rot   <= w_rot_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_work_n  = r_work;
    w_cnt_n   = r_cnt;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
`ifdef SLL_64B_ITER_ROTATE_EN
    w_rot_n   = r_rot;
`endif
    case (r_state)
      IDLE: begin
        if (init_i) begin
          if (shift_i == '0) begin
            // Shift or rotate by zero is the identity: finish on this edge.
            w_data_n = data_i;
            w_done_n = 1'b1;
          end else begin
            w_work_n  = data_i;
            w_cnt_n   = {1'b0, shift_i};
            w_state_n = SHIFT;
`ifdef SLL_64B_ITER_ROTATE_EN
            w_rot_n   = rot_i;
`endif
          end
        end
      end
      SHIFT: begin
        w_work_n = w_step;
        w_cnt_n  = r_cnt - w_amt;
        // Last step: amt equals the remaining count, so the step output
        // is the final result.
        if (r_cnt <= STEP) begin
          w_data_n  = w_step;
          w_done_n  = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign busy_o      = (r_state == SHIFT);
  assign done_o      = r_done;
  assign data_o      = r_data;
  assign dbg_state_o = r_state;

endmodule

// File: doc/sll_64b_iter.md
Name: sll_64b_iter

Overview:
Iterative 64-bit logical left shifter. It is the left-shift counterpart of the single-cycle right shifter in the ALU datapath. It trades latency for area by shifting at most STEP bits per clock under a small FSM. It uses the same init/done handshake as the other shift units, so the ALU sequencer can issue to either unit interchangeably.

Parameters:
- STEP_LOG2, 2, log2 of the maximum bits shifted per cycle. Legal range is 0..5. STEP = 2**STEP_LOG2.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- init_i  input  1  start request; sampled only in IDLE.
- busy_o  output  1  high while an operation is in progress (SHIFT state).
- done_o  output  1  one-cycle pulse; data_o is valid from this cycle on.
- shift_i  input  6  shift amount, 0..63; sampled with init_i.
- data_i  input  64  operand; sampled with init_i.
- data_o  output  64  result; holds its value until the next done_o.

Behaviour:
- Reset (rst_i high, asynchronous): state=IDLE; busy_o=0; done_o=0; data_o=0; internal work register=0; remaining count=0.
- States:
  - IDLE: wait for init_i.
  - SHIFT: iterate.
- IDLE with init_i=1:
  - shift_i=0: data_o<=data_i, done_o<=1, stay in IDLE. Latency is 1 edge.
  - shift_i>0: work<=data_i, cnt<=shift_i, busy_o<=1, go to SHIFT.
- IDLE with init_i=0: done_o<=0; data_o holds.
- SHIFT, each edge:
  - amt = min(cnt, STEP).
  - work<=work<<amt, zero-filled from the LSB.
  - cnt<=cnt-amt.
- SHIFT with cnt<=STEP (last step):
  - data_o<=(work<<cnt).
  - done_o<=1, busy_o<=0, go to IDLE.
- Latency from the init edge to done_o high is 1+ceil(shift_i/STEP) edges. With STEP=4 and shift 63, done_o rises 17 edges after init.
- init_i while in SHIFT is ignored: no queuing, and shift_i/data_i are not resampled.
- init_i in the cycle done_o is high is accepted (state is IDLE). Back-to-back operations need no idle gap.
- done_o is high for exactly one cycle per accepted init.
- data_o changes only on a done edge; it never shows intermediate values.
- cnt is 7 bits wide, so min() compares without overflow. The shift amount never exceeds 63, so there is no shift-out-of-range case.
- STEP_LOG2=5: at most 2 SHIFT cycles. STEP_LOG2=0: up to 63 SHIFT cycles.
- Reset asserted mid-operation aborts immediately to reset values. No done_o is produced for the aborted operation.

Optional Feature:
- Macro: SLL_64B_ITER_ROTATE_EN.
- When defined:
  - Extra port rot_i (input, 1), sampled with init_i and held internally for the operation.
  - When rot_i=1, each step rotates left instead of zero-filling: work<={work[63-amt:0], work[63:64-amt]}, with amt=0 leaving work unchanged.
  - The last step and the shift_i=0 path apply the same rotation.
- When not defined: the port is absent and all shifts are logical.

Decomposition:
- Package sll_64b_pkg holds:
  - typedef enum logic [0:0] {IDLE, SHIFT} sll_state_t
  - localparam DATA_W=64
  - localparam SHAMT_W=6
  - function step_amt(cnt, step), returning min(cnt, step)
- One sub-module is natural: sll_64b_step, a combinational shift/rotate of a 64-bit word by amt in 0..STEP, used once in the datapath.

Test Plan:
- Reset mid-op: rst_i high while in SHIFT -> busy_o=0, done_o=0, data_o=0 at once; no later done_o.
- STEP_LOG2=2, data_i=64'h0000_0000_0000_0001, shift_i=63 -> done_o high exactly 17 edges after init; data_o=64'h8000_0000_0000_0000; busy_o high for 16 cycles.
- shift_i=0, data_i=64'hDEAD_BEEF_0123_4567 -> done_o on the next edge; data_o equals data_i; busy_o never high.
- shift_i=5, data_i=64'hFFFF_FFFF_FFFF_FFFF, with a second init (shift 1, data 1) pulsed during busy -> result 64'hFFFF_FFFF_FFFF_FFE0 after 3 edges; the second init is ignored; exactly one done_o.
- Back-to-back: init asserted in the done_o cycle with shift_i=4, data_i=64'h1 -> accepted; data_o=64'h10 two edges later.
- SLL_64B_ITER_ROTATE_EN, rot_i=1, data_i=64'h8000_0000_0000_0001, shift_i=1 -> data_o=64'h0000_0000_0000_0003.
